// File: rtl/mult_host_pkg.sv
// Shared types and defaults for the multiplier-core host sequencer.
// The state encoding is also exported on the sequencer's debug port.
package mult_host_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 1023;
    localparam int DEF_CNT_W   = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRV_A = 3'd1,
        DRV_B = 3'd2,
        TURN  = 3'd3,
        START = 3'd4,
        WAIT  = 3'd5,
        HOLD  = 3'd6
    } state_t;

endpackage

// File: rtl/mult_host_wdog.sv
// Watchdog for the WAIT phase: counts enabled cycles since the last clear.
// o_tc marks the enabled cycle that is the TIMEOUT-th one since the clear.
module mult_host_wdog #(
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Comparing the post-increment value counts the current cycle as elapsed.
    assign o_tc = i_en && (w_cnt_nxt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mult_host_seq.sv
// Initiator-side sequencer for the multiplier core: loads operands over the
// shared Z bus, starts the core, and buffers its result for downstream.
module mult_host_seq
    import mult_host_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_err,
    output logic             busy,
    output logic             core_start,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_a,
    input  logic [WIDTH-1:0] core_b,
    output logic             z_ld_a,
    output logic             z_ld_b,
    inout  wire  [WIDTH-1:0] Z,
    output state_t           o_dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; the sender holds its data stable until then.

    state_t           r_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_z_data;
    logic             r_z_oe;
    logic             r_z_ld_a;
    logic             r_z_ld_b;
    logic             r_core_start;
    logic             r_done_armed;
    logic             r_res_valid;
    logic             r_res_err;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic             w_tc;

    mult_host_wdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (r_state == START),
        .i_en  (r_state == WAIT),
        .o_tc  (w_tc)
    );

    // Output enable is a register with async clear, so Z floats as soon as rst falls.
    assign Z = r_z_oe ? r_z_data : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_b          <= '0;
            r_z_data     <= '0;
            r_z_oe       <= 1'b0;
            r_z_ld_a     <= 1'b0;
            r_z_ld_b     <= 1'b0;
            r_core_start <= 1'b0;
            r_done_armed <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_err    <= 1'b0;
            r_res_hi     <= '0;
            r_res_lo     <= '0;
        end else begin
            r_z_ld_a     <= 1'b0;
            r_z_ld_b     <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        r_z_data <= op_a;
                        r_b      <= op_b;
                        r_z_oe   <= 1'b1;
                        r_z_ld_a <= 1'b1;
                        r_state  <= DRV_A;
                    end
                end
                DRV_A: begin
                    r_z_data <= r_b;
                    r_z_ld_b <= 1'b1;
                    r_state  <= DRV_B;
                end
                DRV_B: begin
                    r_z_oe  <= 1'b0;
                    r_state <= TURN;
                end
                TURN: begin
                    r_core_start <= 1'b1;
                    r_state      <= START;
                end
                START: begin
                    // A low done seen while the start pulse is out already arms capture.
                    r_done_armed <= ~core_done;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (r_done_armed && core_done) begin
                        r_res_hi    <= core_a;
                        r_res_lo    <= core_b;
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (w_tc) begin
                        r_res_hi    <= '0;
                        r_res_lo    <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (!core_done) begin
                        r_done_armed <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign res_valid   = r_res_valid;
    assign res_err     = r_res_err;
    assign res_hi      = r_res_hi;
    assign res_lo      = r_res_lo;
    assign core_start  = r_core_start;
    assign z_ld_a      = r_z_ld_a;
    assign z_ld_b      = r_z_ld_b;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_host_seq.sv
// Directed bench for mult_host_seq: table of operations against a scripted
// core, plus hand-written asynchronous reset sequences.
module tb_mult_host_seq;
  import mult_host_pkg::*;

  localparam int W  = 32;
  localparam int TO = 15;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic         core_done = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] core_a = '0;
  logic [W-1:0] core_b = '0;
  logic         op_ready, res_valid, res_err, busy, core_start, z_ld_a, z_ld_b;
  logic [W-1:0] res_hi, res_lo;
  wire  [W-1:0] Z;
  state_t       dbg_state;

  int checks = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];

  // Cycle numbers count from the accept cycle (0); rise/stale_end of -1 mean "never".
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    int           stale_end;
    int           rise;
    int           exp_cyc;
    int           hold;
    logic         busy_valid;
    logic         exp_err;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[7];

  mult_host_seq #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err),
    .busy(busy), .core_start(core_start), .core_done(core_done),
    .core_a(core_a), .core_b(core_b),
    .z_ld_a(z_ld_a), .z_ld_b(z_ld_b), .Z(Z),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // A 2-state simulator reads an undriven net as zero; a 4-state one as z.
  task automatic chk_zrel(input string name);
    checks++;
    if (!((Z === {W{1'bz}}) || (Z === '0))) begin
      failures++;
      $display("FAIL %s: Z=0x%08h expected released at %0t", name, Z, $time);
    end
  endtask

  function automatic logic done_at(input vec_t v, input int c);
    return (c <= v.stale_end) || (v.rise >= 0 && c >= v.rise);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_err"}, 32'(res_err), 32'd0);
    chk({tag, "_res_hi"}, res_hi, 32'd0);
    chk({tag, "_res_lo"}, res_lo, 32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_z_ld_a"}, 32'(z_ld_a), 32'd0);
    chk({tag, "_z_ld_b"}, 32'(z_ld_b), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk_zrel({tag, "_z"});
  endtask

  // driver: one full operation, entered and left on a negedge with the DUT idle
  task automatic do_op(input vec_t v);
    logic [2*W:0] e;
    exp_q.push_back({v.exp_err, v.exp_hi, v.exp_lo});
    chk("accept_op_ready", 32'(op_ready), 32'd1);
    op_a = v.a; op_b = v.b; op_valid = 1'b1;
    core_a = v.ca; core_b = v.cb;
    core_done = done_at(v, 0);
    for (int c = 1; c <= v.exp_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (v.busy_valid) begin
          op_a = ~v.a; op_b = ~v.b;
        end else begin
          op_valid = 1'b0;
        end
      end
      chk("busy_op_ready", 32'(op_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      chk("z_ld_a", 32'(z_ld_a), 32'(c == 1));
      chk("z_ld_b", 32'(z_ld_b), 32'(c == 2));
      chk("core_start", 32'(core_start), 32'(c == 4));
      chk("res_valid_timing", 32'(res_valid), 32'(c == v.exp_cyc));
      if (c == 1) chk("z_drive_a", Z, v.a);
      else if (c == 2) chk("z_drive_b", Z, v.b);
      else chk_zrel("z_released");
      core_done = done_at(v, c);
    end
    // scoreboard
    e = exp_q.pop_front();
    chk("res_err", 32'(res_err), 32'(e[2*W]));
    chk("res_hi", res_hi, e[2*W-1:W]);
    chk("res_lo", res_lo, e[W-1:0]);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_op_ready", 32'(op_ready), 32'd0);
      chk("hold_err", 32'(res_err), 32'(e[2*W]));
      chk("hold_hi", res_hi, e[2*W-1:W]);
      chk("hold_lo", res_lo, e[W-1:0]);
    end
    res_ready = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0; core_done = 1'b0;
    chk("release_valid", 32'(res_valid), 32'd0);
    chk("release_op_ready", 32'(op_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_state", 32'(dbg_state), 32'(IDLE));
  endtask

  // launch an operation, stop at cycle rc, then pull reset low between edges
  task automatic launch_and_reset(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input int rc, input string tag);
    op_a = a; op_b = b; op_valid = 1'b1; core_done = 1'b0;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      if (c == 1) op_valid = 1'b0;
    end
    chk({tag, "_pre_z_ld_b"}, 32'(z_ld_b), 32'(rc == 2));
    chk({tag, "_pre_core_start"}, 32'(core_start), 32'(rc == 4));
    if (rc == 2) chk({tag, "_pre_z"}, Z, b);
    #2 rst = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //            a             b             ca            cb            stale rise cyc hold bv err hi            lo
    vecs[0] = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F,  -1,   7,  8,  0, 1'b0, 1'b0, 32'h00000000, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFFF, 32'h80000001, 32'hDEADBEEF, 32'h12345678,  -1,   5,  6,  0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{32'h00000007, 32'h00000009, 32'hA5A5A5A5, 32'h5A5A5A5A,   8,  10, 11,  0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[3] = '{32'h00000010, 32'h00000020, 32'h11111111, 32'h22222222,  -1,  -1, 20, 10, 1'b1, 1'b1, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'h00000021, 32'h00000043, 32'hCAFEF00D, 32'h0BADBEEF,  -1,  19, 20,  0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF};
    vecs[5] = '{32'h00000031, 32'h00000032, 32'h01020304, 32'h05060708,  -1,  18, 19,  2, 1'b0, 1'b0, 32'h01020304, 32'h05060708};
    vecs[6] = '{32'h00000044, 32'h00000055, 32'h77777777, 32'h88888888, 100,  -1, 20,  0, 1'b0, 1'b1, 32'h00000000, 32'h00000000};

    #1 rst = 1'b0;
    #1 check_reset_vals("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    launch_and_reset(32'h000000AA, 32'h00000055, 2, "rst_drv_b");
    @(negedge clk);
    do_op(vecs[0]);
    launch_and_reset(32'h000000BB, 32'h00000066, 4, "rst_start");
    @(negedge clk);
    do_op(vecs[1]);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
